// File: rtl/adsd_mem_arbiter_if.sv
// Requester and memory-side signals of the ADSD unified-memory arbiter.
// The arbiter takes the slave view; the datapath/memory environment takes the master view.
interface adsd_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // Instruction-fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;

  // Load/store requester
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_done;

  // Shared read return and memory port
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  mem_rdata,
    output if_gnt, if_done, ls_gnt, ls_done, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output mem_rdata,
    input  if_gnt, if_done, ls_gnt, ls_done, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/adsd_mem_arbiter.sv
// Single-port memory arbiter for the ADSD RISC core: load/store has priority over
// instruction fetch, bounded by a starvation counter. One access in flight, registered controls.
module adsd_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STARVE = 3
) (
  input logic             clk,
  input logic             rst,
  adsd_mem_arbiter_if.slave bus
);

  localparam int LCW = $clog2(MEM_LAT + 1);
  localparam int SCW = $clog2(MAX_STARVE + 1);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_WAIT
  } state_e;

  typedef enum logic [0:0] {
    OWN_IF,
    OWN_LS
  } owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [LCW-1:0]  lat_q, lat_d;
  logic [SCW-1:0]  starve_q, starve_d;

  logic            if_gnt_q, if_gnt_d;
  logic            if_done_q, if_done_d;
  logic            ls_gnt_q, ls_gnt_d;
  logic            ls_done_q, ls_done_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic            any_req;
  logic            contested;
  logic            starved;
  logic            pick_ls;

  // Winner selection: LS by default, IF once LS has won MAX_STARVE contested rounds.
  always_comb begin
    any_req   = bus.if_req | bus.ls_req;
    contested = bus.if_req & bus.ls_req;
    starved   = (starve_q >= SCW'(MAX_STARVE));
    pick_ls   = bus.ls_req & ~(contested & starved);
  end

  // NOTE: every _d signal gets its default first so no branch can infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    if_gnt_d    = 1'b0;
    if_done_d   = 1'b0;
    ls_gnt_d    = 1'b0;
    ls_done_d   = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d  = ST_WAIT;
          lat_d    = LCW'(MEM_LAT);
          mem_en_d = 1'b1;
          if (pick_ls) begin
            owner_d     = OWN_LS;
            ls_gnt_d    = 1'b1;
            mem_we_d    = bus.ls_we;
            mem_addr_d  = bus.ls_addr;
            mem_wdata_d = bus.ls_wdata;
            starve_d    = contested ? starve_q + SCW'(1) : '0;
          end else begin
            owner_d     = OWN_IF;
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end
        end
      end

      ST_WAIT: begin
        lat_d = lat_q - LCW'(1);
        // The edge that sees a count of one opens the done cycle, which is IDLE again.
        if (lat_q == LCW'(1)) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_LS) ls_done_d = 1'b1;
          else                   if_done_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      lat_q       <= '0;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      ls_gnt_q    <= 1'b0;
      ls_done_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      if_gnt_q    <= if_gnt_d;
      if_done_q   <= if_done_d;
      ls_gnt_q    <= ls_gnt_d;
      ls_done_q   <= ls_done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_done   = if_done_q;
  assign bus.ls_gnt    = ls_gnt_q;
  assign bus.ls_done   = ls_done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  // Read data is not re-registered; done pulses qualify it.
  assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_adsd_mem_arbiter.sv
// Directed bench for adsd_mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each with a behavioural memory and per-requester expected-result queues.
module tb_adsd_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t if_q1[$];
  exp_t ls_q1[$];
  exp_t if_q3[$];
  exp_t ls_q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adsd_mem_arbiter_if #(.AW(16), .DW(16)) bus1 ();
  adsd_mem_arbiter_if #(.AW(16), .DW(16)) bus3 ();

  adsd_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .MAX_STARVE(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  adsd_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3), .MAX_STARVE(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Behavioural memories: read data appears MEM_LAT cycles after the mem_en cycle.
  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];
  logic [15:0] rd1;
  logic [15:0] rd3_p0, rd3_p1, rd3_p2;
  logic        mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      mem1[8'h04]   <= 16'h1234;
      mem1[8'h10]   <= 16'h1111;
      mem1[8'h20]   <= 16'h2222;
      mem1[8'hF0]   <= 16'h0000;
      mem3[8'h30]   <= 16'h3333;
      mem3[8'h40]   <= 16'h4444;
      mem_init_done <= 1'b1;
    end else begin
      if (bus1.mem_en) begin
        if (bus1.mem_we) mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
        rd1 <= mem1[bus1.mem_addr[7:0]];
      end
      if (bus3.mem_en) begin
        if (bus3.mem_we) mem3[bus3.mem_addr[7:0]] <= bus3.mem_wdata;
        rd3_p0 <= mem3[bus3.mem_addr[7:0]];
      end
    end
    rd3_p1 <= rd3_p0;
    rd3_p2 <= rd3_p1;
  end

  assign bus1.mem_rdata = rd1;
  assign bus3.mem_rdata = rd3_p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: grants are checked against the queue head, done pops it.
  int  g1_cyc = 0;
  logic g1_ls = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      check("m1_en_is_gnt", bus1.mem_en, bus1.if_gnt | bus1.ls_gnt);
      if (bus1.if_gnt) begin
        check("m1_ifq_nonempty", 32'(if_q1.size() != 0), 1);
        if (if_q1.size() != 0) check("m1_if_addr", bus1.mem_addr, if_q1[0].addr);
        check("m1_if_we", bus1.mem_we, 0);
        g1_cyc = cyc;
        g1_ls  = 1'b0;
      end
      if (bus1.ls_gnt) begin
        check("m1_lsq_nonempty", 32'(ls_q1.size() != 0), 1);
        if (ls_q1.size() != 0) begin
          check("m1_ls_addr", bus1.mem_addr, ls_q1[0].addr);
          check("m1_ls_we", bus1.mem_we, ls_q1[0].we);
          if (ls_q1[0].we) check("m1_ls_wdata", bus1.mem_wdata, ls_q1[0].wdata);
        end
        g1_cyc = cyc;
        g1_ls  = 1'b1;
      end
      if (bus1.if_done) begin
        check("m1_ifdone_owner", g1_ls, 0);
        check("m1_ifdone_lat", cyc - g1_cyc, 1);
        check("m1_ifdone_q", 32'(if_q1.size() != 0), 1);
        if (if_q1.size() != 0) begin
          e = if_q1.pop_front();
          check("m1_if_rdata", bus1.rdata, e.rdata);
        end
      end
      if (bus1.ls_done) begin
        check("m1_lsdone_owner", g1_ls, 1);
        check("m1_lsdone_lat", cyc - g1_cyc, 1);
        check("m1_lsdone_q", 32'(ls_q1.size() != 0), 1);
        if (ls_q1.size() != 0) begin
          e = ls_q1.pop_front();
          if (!e.we) check("m1_ls_rdata", bus1.rdata, e.rdata);
        end
      end
    end
  end

  int  g3_cyc = 0;
  logic g3_ls = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      check("m3_en_is_gnt", bus3.mem_en, bus3.if_gnt | bus3.ls_gnt);
      if (bus3.if_gnt) begin
        check("m3_ifq_nonempty", 32'(if_q3.size() != 0), 1);
        if (if_q3.size() != 0) check("m3_if_addr", bus3.mem_addr, if_q3[0].addr);
        g3_cyc = cyc;
        g3_ls  = 1'b0;
      end
      if (bus3.ls_gnt) begin
        check("m3_lsq_nonempty", 32'(ls_q3.size() != 0), 1);
        if (ls_q3.size() != 0) check("m3_ls_addr", bus3.mem_addr, ls_q3[0].addr);
        g3_cyc = cyc;
        g3_ls  = 1'b1;
      end
      if (bus3.if_done) begin
        check("m3_ifdone_owner", g3_ls, 0);
        check("m3_ifdone_lat", cyc - g3_cyc, 3);
        check("m3_ifdone_q", 32'(if_q3.size() != 0), 1);
        if (if_q3.size() != 0) begin
          e = if_q3.pop_front();
          check("m3_if_rdata", bus3.rdata, e.rdata);
        end
      end
      if (bus3.ls_done) begin
        check("m3_lsdone_owner", g3_ls, 1);
        check("m3_lsdone_lat", cyc - g3_cyc, 3);
        check("m3_lsdone_q", 32'(ls_q3.size() != 0), 1);
        if (ls_q3.size() != 0) begin
          e = ls_q3.pop_front();
          if (!e.we) check("m3_ls_rdata", bus3.rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit exp_ls [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int n;
    int prev;

    rst = 1'b1;
    bus1.if_req = 1'b1; bus1.if_addr = 16'h0004;
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 16'h0010; bus1.ls_wdata = 16'h0000;
    bus3.if_req = 1'b0; bus3.if_addr = 16'h0000;
    bus3.ls_req = 1'b0; bus3.ls_we = 1'b0; bus3.ls_addr = 16'h0000; bus3.ls_wdata = 16'h0000;
    ls_q1.push_back('{we: 1'b0, addr: 16'h0010, wdata: 16'h0000, rdata: 16'h1111});
    if_q1.push_back('{we: 1'b0, addr: 16'h0004, wdata: 16'h0000, rdata: 16'h1234});

    // Reset held two edges with both requests pending.
    @(negedge clk);
    check("rst_if_gnt", bus1.if_gnt, 0);
    check("rst_ls_gnt", bus1.ls_gnt, 0);
    check("rst_mem_en", bus1.mem_en, 0);
    check("rst_mem_addr", bus1.mem_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ls_gnt", bus1.ls_gnt, 0);
    check("post_rst_if_gnt", bus1.if_gnt, 0);
    check("post_rst_mem_en", bus1.mem_en, 0);
    check("post_rst_mem_we", bus1.mem_we, 0);
    check("post_rst_mem_wdata", bus1.mem_wdata, 0);
    @(negedge clk);
    check("first_gnt_ls", bus1.ls_gnt, 1);
    check("first_gnt_not_if", bus1.if_gnt, 0);
    check("first_gnt_addr", bus1.mem_addr, 16'h0010);
    @(posedge clk); #1 bus1.ls_req = 1'b0;
    @(negedge clk);
    check("first_ls_done", bus1.ls_done, 1);
    check("first_ls_rdata", bus1.rdata, 16'h1111);

    // IF read of 0x0004 follows once LS has dropped.
    @(posedge clk); #1 bus1.if_req = 1'b0;
    @(negedge clk);
    check("if_rd_gnt", bus1.if_gnt, 1);
    check("if_rd_mem_en", bus1.mem_en, 1);
    check("if_rd_addr", bus1.mem_addr, 16'h0004);
    check("if_rd_we", bus1.mem_we, 0);
    @(negedge clk);
    check("if_rd_done", bus1.if_done, 1);
    check("if_rd_rdata", bus1.rdata, 16'h1234);

    // Store 0xBEEF to 0x00F0, then read it back through IF.
    @(posedge clk); #1;
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b1; bus1.ls_addr = 16'h00F0; bus1.ls_wdata = 16'hBEEF;
    ls_q1.push_back('{we: 1'b1, addr: 16'h00F0, wdata: 16'hBEEF, rdata: 16'h0000});
    @(posedge clk); #1;
    bus1.ls_req = 1'b0; bus1.ls_we = 1'b0; bus1.ls_addr = 16'h0000; bus1.ls_wdata = 16'hDEAD;
    bus1.if_req = 1'b1; bus1.if_addr = 16'h00F0;
    if_q1.push_back('{we: 1'b0, addr: 16'h00F0, wdata: 16'h0000, rdata: 16'hBEEF});
    @(negedge clk);
    check("st_gnt", bus1.ls_gnt, 1);
    check("st_we", bus1.mem_we, 1);
    check("st_addr", bus1.mem_addr, 16'h00F0);
    check("st_wdata", bus1.mem_wdata, 16'hBEEF);
    @(negedge clk);
    check("st_done", bus1.ls_done, 1);
    check("st_if_held_off", bus1.if_gnt, 0);
    @(posedge clk); #1 bus1.if_req = 1'b0;
    @(negedge clk);
    check("rb_gnt", bus1.if_gnt, 1);
    @(negedge clk);
    check("rb_done", bus1.if_done, 1);
    check("rb_rdata", bus1.rdata, 16'hBEEF);

    // Both requesters hold their requests; expect LS,LS,LS,IF repeating, 2 cycles apart.
    @(posedge clk); #1;
    bus1.ls_req = 1'b1; bus1.ls_we = 1'b0; bus1.ls_addr = 16'h0010;
    bus1.if_req = 1'b1; bus1.if_addr = 16'h0020;
    for (int i = 0; i < 6; i++) ls_q1.push_back('{we: 1'b0, addr: 16'h0010, wdata: 16'h0000, rdata: 16'h1111});
    for (int i = 0; i < 2; i++) if_q1.push_back('{we: 1'b0, addr: 16'h0020, wdata: 16'h0000, rdata: 16'h2222});
    n = 0;
    prev = 0;
    for (int i = 0; i < 40 && n < 8; i++) begin
      @(negedge clk);
      if (bus1.if_gnt || bus1.ls_gnt) begin
        check($sformatf("starve_kind_%0d", n), bus1.ls_gnt, exp_ls[n]);
        if (n > 0) check($sformatf("starve_gap_%0d", n), cyc - prev, 2);
        prev = cyc;
        n++;
      end
    end
    check("starve_count", n, 8);
    @(posedge clk); #1 bus1.ls_req = 1'b0; bus1.if_req = 1'b0;
    repeat (3) @(negedge clk);
    check("q1_if_drained", if_q1.size(), 0);
    check("q1_ls_drained", ls_q1.size(), 0);

    // MEM_LAT=3: continuous fetch grants every 4 cycles.
    @(posedge clk); #1;
    bus3.if_req = 1'b1; bus3.if_addr = 16'h0030;
    for (int i = 0; i < 3; i++) if_q3.push_back('{we: 1'b0, addr: 16'h0030, wdata: 16'h0000, rdata: 16'h3333});
    n = 0;
    prev = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (bus3.if_gnt) begin
        if (n > 0) check($sformatf("lat3_gap_%0d", n), cyc - prev, 4);
        prev = cyc;
        n++;
      end
    end
    check("lat3_count", n, 3);
    @(posedge clk); #1 bus3.if_req = 1'b0;
    repeat (4) @(negedge clk);
    check("q3_if_drained", if_q3.size(), 0);

    // Reset one cycle after an LS load grant aborts it; the held request is re-granted.
    @(posedge clk); #1;
    bus3.ls_req = 1'b1; bus3.ls_we = 1'b0; bus3.ls_addr = 16'h0040;
    ls_q3.push_back('{we: 1'b0, addr: 16'h0040, wdata: 16'h0000, rdata: 16'h4444});
    n = 0;
    for (int i = 0; i < 20 && n == 0; i++) begin
      @(negedge clk);
      if (bus3.ls_gnt) n = 1;
    end
    check("abort_first_gnt", n, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_no_done_a", bus3.ls_done, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ls_gnt0", bus3.ls_gnt, 0);
    check("abort_ls_done0", bus3.ls_done, 0);
    check("abort_if_gnt0", bus3.if_gnt, 0);
    check("abort_if_done0", bus3.if_done, 0);
    check("abort_mem_en0", bus3.mem_en, 0);
    check("abort_mem_we0", bus3.mem_we, 0);
    check("abort_mem_addr0", bus3.mem_addr, 0);
    check("abort_mem_wdata0", bus3.mem_wdata, 0);
    @(negedge clk);
    check("regrant_ls_gnt", bus3.ls_gnt, 1);
    check("regrant_no_done", bus3.ls_done, 0);
    check("regrant_addr", bus3.mem_addr, 16'h0040);
    @(posedge clk); #1 bus3.ls_req = 1'b0;
    @(negedge clk);
    check("regrant_wait_a", bus3.ls_done, 0);
    @(negedge clk);
    check("regrant_wait_b", bus3.ls_done, 0);
    @(negedge clk);
    check("regrant_done", bus3.ls_done, 1);
    check("regrant_rdata", bus3.rdata, 16'h4444);

    repeat (3) @(negedge clk);
    check("q3_ls_drained", ls_q3.size(), 0);
    check("q1_if_final", if_q1.size(), 0);
    check("q1_ls_final", ls_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
